// File: rtl/fadd_arbiter.sv
// Round-robin front end that shares one fixed-latency fadd pipeline among NREQ
// requesters and routes each result back using a tag pipeline matched to LAT.
module fadd_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 32,
  parameter int LAT  = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              fadd_en,
  output logic [N-1:0]      fadd_op1,
  output logic [N-1:0]      fadd_op2,
  input  logic              fadd_res_val,
  input  logic [N-1:0]      fadd_res,
  output logic [NREQ-1:0]   resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [N-1:0]      resp_data,
  output logic              idle,
  output logic              err
);

  // Handshake: requester i transfers on the rising edge where
  // req_valid[i] & req_ready[i]; operands must stay stable while req_valid is high.

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic           found;
  logic           xfer;
  logic [LAT:0]   tag_vld;
  logic [IDW-1:0] tag_id [LAT+1];

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Search from rr_ptr; nothing is granted while held or in reset.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rst_n && !hold && req_valid[wrap_inc(rr_ptr, k)]) begin
        found    = 1'b1;
        grant_id = wrap_inc(rr_ptr, k);
      end
    end
    if (found) req_ready[grant_id] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      fadd_en  <= 1'b0;
      fadd_op1 <= '0;
      fadd_op2 <= '0;
      tag_vld  <= '0;
      err      <= 1'b0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
    end else begin
      fadd_en   <= xfer;
      tag_vld   <= {tag_vld[LAT-1:0], xfer};
      tag_id[0] <= grant_id;
      for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
      if (xfer) begin
        rr_ptr   <= wrap_inc(grant_id, 1);
        fadd_op1 <= req_op1[int'(grant_id)*N +: N];
        fadd_op2 <= req_op2[int'(grant_id)*N +: N];
      end
      // A result without a matching tag (or vice versa) means the pipelines desynced.
      if (fadd_res_val != tag_vld[LAT]) err <= 1'b1;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (tag_vld[LAT] && fadd_res_val) resp_valid[tag_id[LAT]] = 1'b1;
  end

  assign resp_id   = tag_id[LAT];
  assign resp_data = fadd_res;
  assign idle      = ~|tag_vld;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of grants, latencies and returned sums.
module tb_fadd_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_op1;
  logic [NREQ*N-1:0] req_op2;
  logic [NREQ-1:0]   req_ready;
  logic              hold;
  logic              fadd_en;
  logic [N-1:0]      fadd_op1;
  logic [N-1:0]      fadd_op2;
  logic              fadd_res_val;
  logic [N-1:0]      fadd_res;
  logic [NREQ-1:0]   resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_data;
  logic              idle;
  logic              err;

  fadd_arbiter #(.NREQ(NREQ), .N(N), .LAT(3), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op1(req_op1),
    .req_op2(req_op2), .req_ready(req_ready), .hold(hold), .fadd_en(fadd_en),
    .fadd_op1(fadd_op1), .fadd_op2(fadd_op2), .fadd_res_val(fadd_res_val),
    .fadd_res(fadd_res), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .idle(idle), .err(err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- float helpers ----------------
  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  ex;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    ex = 8'(int'(d[62:52]) - 1023 + 127);
    return {d[63], ex, d[51:29]};
  endfunction

  // ---------------- fadd stand-in: 3-cycle adder, reset by ~rst_n ----------------
  logic [2:0]  p_val;
  logic [31:0] p_res [3];
  logic        inj;

  always @(posedge clk) begin
    if (!rst_n) begin
      p_val <= 3'b000;
      for (int k = 0; k < 3; k++) p_res[k] <= 32'h0;
    end else begin
      p_val    <= {p_val[1:0], fadd_en};
      p_res[0] <= r2f(f2r(fadd_op1) + f2r(fadd_op2));
      p_res[1] <= p_res[0];
      p_res[2] <= p_res[1];
    end
  end

  assign fadd_res_val = p_val[2] | inj;
  assign fadd_res     = p_res[2];

  // ---------------- requester operand storage ----------------
  logic [31:0] opa [NREQ];
  logic [31:0] opb [NREQ];
  logic [31:0] exps [NREQ];

  always_comb begin
    req_op1 = '0;
    req_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op1[i*N +: N] = opa[i];
      req_op2[i*N +: N] = opb[i];
    end
  end

  // ---------------- scoreboard / model ----------------
  // entry = {due_cycle[15:0], id[1:0], data[31:0]}
  logic [49:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rr    = 0;
  int          last_grant = -1;
  logic        m_en  = 1'b0;
  logic [31:0] m_op1 = 32'h0;
  logic [31:0] m_op2 = 32'h0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Check one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic [3:0]  e_ready, e_resp;
    logic [1:0]  e_id;
    logic [31:0] e_data;
    logic        e_idle;
    bit          due_now;
    int          g, due;
    @(negedge clk);
    g = -1;
    if (rst_n && !hold)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (rr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    due_now = 1'b0;
    if (rst_n) begin
      chk("fadd_en", 64'(fadd_en), 64'(m_en));
      chk("fadd_op1", 64'(fadd_op1), 64'(m_op1));
      chk("fadd_op2", 64'(fadd_op2), 64'(m_op2));
      chk("err", 64'(err), 64'(m_err));
      e_resp = 4'b0000; e_idle = 1'b1; e_id = 2'd0; e_data = 32'h0;
      foreach (exp_q[n]) begin
        due = int'(exp_q[n][49:34]);
        if (due == cyc) begin
          due_now = 1'b1;
          e_id    = exp_q[n][33:32];
          e_data  = exp_q[n][31:0];
          e_resp  = 4'b0001 << e_id;
        end
        if (cyc >= due - 3 && cyc <= due) e_idle = 1'b0;
      end
      chk("resp_valid", 64'(resp_valid), 64'(e_resp));
      if (due_now) begin
        chk("resp_id", 64'(resp_id), 64'(e_id));
        chk("resp_data", 64'(resp_data), 64'(e_data));
      end
      chk("idle", 64'(idle), 64'(e_idle));
    end
    if (!rst_n) begin
      rr = 0; exp_q.delete(); m_en = 1'b0; m_op1 = 32'h0; m_op2 = 32'h0; m_err = 1'b0;
    end else begin
      if (inj && !due_now) m_err = 1'b1;
      while (exp_q.size() > 0 && int'(exp_q[0][49:34]) <= cyc) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({16'(cyc + 4), 2'(g), exps[g]});
        rr = (g + 1) % NREQ;
        m_en = 1'b1; m_op1 = opa[g]; m_op2 = opb[g];
      end else begin
        m_en = 1'b0;
      end
    end
    last_grant = g;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
    opa[i] = a; opb[i] = b; exps[i] = s;
  endtask

  task automatic rand_op(input int i);
    real x, y;
    x = real'(int'($urandom_range(0, 32)) - 16) * 0.5;
    y = real'(int'($urandom_range(0, 32)) - 16) * 0.5;
    set_op(i, r2f(x), r2f(y), r2f(x + y));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; hold = 1'b0; req_valid = '0; inj = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    steps(2);
    rst_n = 1'b1;
    chk("rst_op1", 64'(fadd_op1), 64'h0);
    chk("rst_resp_id", 64'(resp_id), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_err", 64'(err), 64'h0);
    steps(2);

    // single op from requester 2: 1.0 + 2.0 = 3.0
    set_op(2, 32'h3F800000, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    steps(5);
    chk("single_idle", 64'(idle), 64'h1);

    // round robin with all requesters valid: 1.5 + 1.5 = 3.0
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3FC00000, 32'h3FC00000, 32'h40400000);
    req_valid = 4'b1111;
    steps(12);
    req_valid = 4'b0000;
    steps(5);

    // hold with three ops in flight
    req_valid = 4'b1111;
    steps(3);
    hold = 1'b1;
    steps(6);
    chk("hold_idle", 64'(idle), 64'h1);
    hold = 1'b0;
    steps(4);
    req_valid = 4'b0000;
    steps(5);

    // lone requester granted every cycle
    req_valid = 4'b0001;
    steps(3);
    req_valid = 4'b0000;
    steps(5);

    // reset with two ops in flight
    req_valid = 4'b1010;
    steps(2);
    req_valid = 4'b0000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    step();
    req_valid = 4'b0000;
    steps(6);
    chk("post_rst_err", 64'(err), 64'h0);

    // mixed signs: 2.5 + -1.5 = 1.0
    set_op(1, 32'h40200000, 32'hBFC00000, 32'h3F800000);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    steps(5);

    // randomized traffic
    for (int i = 0; i < NREQ; i++) rand_op(i);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          if (req_valid[i]) rand_op(i);
        end
      hold = ($urandom_range(0, 7) == 0);
      step();
    end
    req_valid = 4'b0000; hold = 1'b0;
    steps(6);

    // error injection with the tag pipeline empty
    inj = 1'b1;
    step();
    inj = 1'b0;
    steps(3);
    chk("err_sticky", 64'(err), 64'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    steps(2);
    chk("err_cleared", 64'(err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
